// File: rtl/rob_if.sv
// Dispatch, writeback, commit and flush signals of the reorder buffer.
// The rob is the slave; dispatch, execution and commit logic form the master side.
interface rob_if #(
  parameter int DEPTH       = 64,
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 124
);
  logic                   disp2rob_wren0;
  logic [DATA_WIDTH-1:0]  disp2rob_wrdata0;
  logic                   disp2rob_wren1;
  logic [DATA_WIDTH-1:0]  disp2rob_wrdata1;
  logic [INDEX_WIDTH-1:0] rob2disp_instr_cnt;
  logic [INDEX_WIDTH-1:0] rob2disp_instr_id;
  logic                   rob2disp_ready;
  logic                   wb0_valid;
  logic [INDEX_WIDTH-1:0] wb0_robid;
  logic                   wb1_valid;
  logic [INDEX_WIDTH-1:0] wb1_robid;
  logic                   rob_commit0_valid;
  logic [DATA_WIDTH-1:0]  rob_commit0_data;
  logic                   rob_commit1_valid;
  logic [DATA_WIDTH-1:0]  rob_commit1_data;
  logic                   flush_valid;

  modport master (
    output disp2rob_wren0, disp2rob_wrdata0, disp2rob_wren1, disp2rob_wrdata1,
    output wb0_valid, wb0_robid, wb1_valid, wb1_robid, flush_valid,
    input  rob2disp_instr_cnt, rob2disp_instr_id, rob2disp_ready,
    input  rob_commit0_valid, rob_commit0_data, rob_commit1_valid, rob_commit1_data
  );

  modport slave (
    input  disp2rob_wren0, disp2rob_wrdata0, disp2rob_wren1, disp2rob_wrdata1,
    input  wb0_valid, wb0_robid, wb1_valid, wb1_robid, flush_valid,
    output rob2disp_instr_cnt, rob2disp_instr_id, rob2disp_ready,
    output rob_commit0_valid, rob_commit0_data, rob_commit1_valid, rob_commit1_data
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: circular FIFO taking two dispatched instructions per cycle and
// retiring up to two completed instructions per cycle in program order.
module rob #(
  parameter int DEPTH       = 64,
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 124
) (
  input  logic  clock,
  input  logic  reset,
  rob_if.slave  bus
);
  localparam int AW = INDEX_WIDTH - 1;

  typedef logic [INDEX_WIDTH-1:0] ptr_t;
  typedef logic [AW-1:0]          idx_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;

  ptr_t             head, tail, cnt;
  logic [DEPTH-1:0] valid_q, complete_q;
  data_t            payload_q [DEPTH];

  idx_t       head_idx, head1_idx, tail_idx, slot1_idx, wb0_idx, wb1_idx;
  logic       ready, accept, wr0, wr1, commit0, commit1;
  logic [1:0] n_alloc, n_commit;

  // The wrap bit of a writeback id carries no information for marking completion.
  logic unused_wrap;
  assign unused_wrap = bus.wb0_robid[AW] ^ bus.wb1_robid[AW];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    head_idx  = head[AW-1:0];
    head1_idx = idx_t'(head_idx + 1'b1);
    tail_idx  = tail[AW-1:0];
    wb0_idx   = bus.wb0_robid[AW-1:0];
    wb1_idx   = bus.wb1_robid[AW-1:0];

    ready  = (cnt <= ptr_t'(DEPTH - 2));
    accept = ready & ~bus.flush_valid;
    wr0    = accept & bus.disp2rob_wren0;
    wr1    = accept & bus.disp2rob_wren1;
    // A lone slot-1 write takes the tail, just like a lone slot-0 write.
    slot1_idx = wr0 ? idx_t'(tail_idx + 1'b1) : tail_idx;
    n_alloc   = {1'b0, wr0} + {1'b0, wr1};

    commit0  = ~bus.flush_valid & valid_q[head_idx] & complete_q[head_idx];
    commit1  = commit0 & valid_q[head1_idx] & complete_q[head1_idx];
    n_commit = {1'b0, commit0} + {1'b0, commit1};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush_valid) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + ptr_t'(n_commit);
      tail <= tail + ptr_t'(n_alloc);
      cnt  <= cnt + ptr_t'(n_alloc) - ptr_t'(n_commit);
    end
  end

  // Later assignments win: writeback, then retire clears, then allocation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
    end else if (bus.flush_valid) begin
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      if (bus.wb0_valid && valid_q[wb0_idx]) complete_q[wb0_idx] <= 1'b1;
      if (bus.wb1_valid && valid_q[wb1_idx]) complete_q[wb1_idx] <= 1'b1;
      if (commit0) begin
        valid_q[head_idx]    <= 1'b0;
        complete_q[head_idx] <= 1'b0;
      end
      if (commit1) begin
        valid_q[head1_idx]    <= 1'b0;
        complete_q[head1_idx] <= 1'b0;
      end
      if (wr0) begin
        valid_q[tail_idx]    <= 1'b1;
        complete_q[tail_idx] <= 1'b0;
      end
      if (wr1) begin
        valid_q[slot1_idx]    <= 1'b1;
        complete_q[slot1_idx] <= 1'b0;
      end
    end
  end

  // NOTE: the payload array has no reset; the valid bits gate its use, and a
  // reset-free array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr0) payload_q[tail_idx]  <= bus.disp2rob_wrdata0;
    if (wr1) payload_q[slot1_idx] <= bus.disp2rob_wrdata1;
  end

  assign bus.rob2disp_instr_cnt = cnt;
  assign bus.rob2disp_instr_id  = tail;
  assign bus.rob2disp_ready     = ready;
  assign bus.rob_commit0_valid  = commit0;
  assign bus.rob_commit1_valid  = commit1;
  assign bus.rob_commit0_data   = payload_q[head_idx];
  assign bus.rob_commit1_data   = payload_q[head1_idx];
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: expected retirements go into a queue at allocation and a
// negedge monitor pops and compares them whenever a commit valid is shown.
module tb_rob;
  typedef logic [123:0] data_t;
  typedef logic [6:0]   ptr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rob_if bus ();
  rob dut (.clock(clock), .reset(reset), .bus(bus.slave));

  int    n_tests = 0;
  int    n_fail  = 0;
  data_t exp_q[$];
  logic [63:0] pc;

  function automatic data_t mk(input logic [63:0] p);
    return {p, ~p[31:0], p[6:2], p[7:3], p[8:4], p[9:4], p[10:5], p[2]};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.disp2rob_wren0 = 1'b0;
    bus.disp2rob_wren1 = 1'b0;
    bus.wb0_valid      = 1'b0;
    bus.wb1_valid      = 1'b0;
    bus.flush_valid    = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic alloc2(input bit push);
    bus.disp2rob_wren0   = 1'b1;
    bus.disp2rob_wrdata0 = mk(pc);
    bus.disp2rob_wren1   = 1'b1;
    bus.disp2rob_wrdata1 = mk(pc + 64'd4);
    if (push) begin
      exp_q.push_back(mk(pc));
      exp_q.push_back(mk(pc + 64'd4));
    end
    pc = pc + 64'd8;
  endtask

  task automatic alloc1(input bit use_slot1, input bit push);
    if (use_slot1) begin
      bus.disp2rob_wren1   = 1'b1;
      bus.disp2rob_wrdata1 = mk(pc);
    end else begin
      bus.disp2rob_wren0   = 1'b1;
      bus.disp2rob_wrdata0 = mk(pc);
    end
    if (push) exp_q.push_back(mk(pc));
    pc = pc + 64'd4;
  endtask

  task automatic wb(input int port, input ptr_t id);
    if (port == 0) begin
      bus.wb0_valid = 1'b1;
      bus.wb0_robid = id;
    end else begin
      bus.wb1_valid = 1'b1;
      bus.wb1_robid = id;
    end
  endtask

  // Scoreboard monitor: every commit valid seen mid-cycle retires on the next edge.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.rob_commit0_valid) begin
        if (exp_q.size() == 0) check("commit0 unexpected", 1, 0);
        else check("commit0 data", bus.rob_commit0_data, exp_q.pop_front());
      end
      if (bus.rob_commit1_valid) begin
        if (exp_q.size() == 0) check("commit1 unexpected", 1, 0);
        else check("commit1 data", bus.rob_commit1_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    clear_inputs();
    bus.disp2rob_wrdata0 = '0;
    bus.disp2rob_wrdata1 = '0;
    bus.wb0_robid        = '0;
    bus.wb1_robid        = '0;
    pc = 64'h1000;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset and idle
    check("reset cnt", bus.rob2disp_instr_cnt, 0);
    check("reset id", bus.rob2disp_instr_id, 0);
    check("reset ready", bus.rob2disp_ready, 1);
    check("reset c0v", bus.rob_commit0_valid, 0);
    check("reset c1v", bus.rob_commit1_valid, 0);
    step();
    check("idle cnt", bus.rob2disp_instr_cnt, 0);

    // Dual allocate, out-of-order writeback, dual retire
    alloc2(1); step();
    check("dual cnt", bus.rob2disp_instr_cnt, 2);
    check("dual id", bus.rob2disp_instr_id, 2);
    wb(0, 7'd1); step();
    check("younger done c0v", bus.rob_commit0_valid, 0);
    wb(0, 7'd0); step();
    check("both done c0v", bus.rob_commit0_valid, 1);
    check("both done c1v", bus.rob_commit1_valid, 1);
    step();
    check("retired cnt", bus.rob2disp_instr_cnt, 0);
    check("retired id", bus.rob2disp_instr_id, 2);

    bus.flush_valid = 1'b1; step();
    check("realign id", bus.rob2disp_instr_id, 0);

    // Fill to full
    pc = 64'h8000;
    for (int i = 0; i < 31; i++) begin
      alloc2(1); step();
    end
    check("62 cnt", bus.rob2disp_instr_cnt, 62);
    check("62 ready", bus.rob2disp_ready, 1);
    alloc2(1); step();
    check("full cnt", bus.rob2disp_instr_cnt, 64);
    check("full ready", bus.rob2disp_ready, 0);
    check("full id", bus.rob2disp_instr_id, 7'h40);
    alloc1(0, 0); step();
    check("drop cnt", bus.rob2disp_instr_cnt, 64);
    check("drop id", bus.rob2disp_instr_id, 7'h40);
    bus.flush_valid = 1'b1;
    exp_q.delete();
    step();
    check("empty after full", bus.rob2disp_instr_cnt, 0);

    // Wrap-around: 63 singles, then a pair straddling indices 63 and 0
    pc = 64'h2000;
    for (int i = 0; i < 63; i++) begin
      alloc1(0, 1); step();
      wb(0, ptr_t'(i)); step();
      step();
    end
    check("pre-wrap id", bus.rob2disp_instr_id, 7'h3F);
    check("pre-wrap cnt", bus.rob2disp_instr_cnt, 0);
    alloc2(1); step();
    check("wrap id", bus.rob2disp_instr_id, 7'h41);
    check("wrap cnt", bus.rob2disp_instr_cnt, 2);
    wb(0, 7'h3F); wb(1, 7'h40); step();
    check("wrap c0v", bus.rob_commit0_valid, 1);
    check("wrap c1v", bus.rob_commit1_valid, 1);
    step();
    check("wrap retired cnt", bus.rob2disp_instr_cnt, 0);

    // Allocate and retire in the same cycle at cnt=10
    pc = 64'h3000;
    for (int i = 0; i < 5; i++) begin
      alloc2(1); step();
    end
    check("ten cnt", bus.rob2disp_instr_cnt, 10);
    check("ten id", bus.rob2disp_instr_id, 7'h4B);
    wb(0, 7'h41); wb(1, 7'h42); step();
    check("ten c1v", bus.rob_commit1_valid, 1);
    alloc2(1); step();
    check("same-cycle cnt", bus.rob2disp_instr_cnt, 10);
    check("same-cycle id", bus.rob2disp_instr_id, 7'h4D);
    check("same-cycle c0v", bus.rob_commit0_valid, 0);
    check("head advanced", bus.rob_commit0_data, mk(64'h3008));

    // Flush at cnt=20 with a retire pending and concurrent wren0/wb0
    for (int i = 0; i < 5; i++) begin
      alloc2(1); step();
    end
    check("twenty cnt", bus.rob2disp_instr_cnt, 20);
    wb(0, 7'h43); wb(1, 7'h44); step();
    bus.flush_valid = 1'b1;
    alloc1(0, 0);
    wb(0, 7'h45);
    #1;
    check("flush c0v", bus.rob_commit0_valid, 0);
    check("flush c1v", bus.rob_commit1_valid, 0);
    exp_q.delete();
    step();
    check("post-flush cnt", bus.rob2disp_instr_cnt, 0);
    check("post-flush id", bus.rob2disp_instr_id, 0);
    check("post-flush ready", bus.rob2disp_ready, 1);
    check("post-flush c0v", bus.rob_commit0_valid, 0);
    wb(0, 7'h45); wb(1, 7'h40); step();
    check("stale wb cnt", bus.rob2disp_instr_cnt, 0);
    check("stale wb c0v", bus.rob_commit0_valid, 0);

    // A lone slot-1 write lands at index 0 and starts incomplete
    pc = 64'h4000;
    alloc1(1, 1); step();
    check("slot1 cnt", bus.rob2disp_instr_cnt, 1);
    check("slot1 incomplete", bus.rob_commit0_valid, 0);
    wb(1, 7'h00); step();
    check("slot1 c0v", bus.rob_commit0_valid, 1);
    check("slot1 c1v", bus.rob_commit1_valid, 0);
    step();
    check("final cnt", bus.rob2disp_instr_cnt, 0);
    check("final id", bus.rob2disp_instr_id, 1);
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
